// File: rtl/key_pkg.sv
// Shared widths and FSM encoding for the key fetch path.
package key_pkg;

  localparam int unsigned addr_bits  = 5;
  localparam int unsigned data_width = 128;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StOut   = 2'd3
  } key_state_e;

endpackage

// File: rtl/ROM_key.sv
// Key ROM with a registered output; a read with en low returns zero.
module ROM_key (
  input  logic                           clk,
  input  logic                           en,
  input  logic [key_pkg::addr_bits-1:0]  addr,
  output logic [key_pkg::data_width-1:0] dout
);
  import key_pkg::*;

  function automatic logic [data_width-1:0] rom_word(input logic [addr_bits-1:0] idx);
    logic [data_width-1:0] word;
    unique case (idx)
      5'd0:    word = 128'hf69f2445df4f9b17ad2b417be66c3710;
      5'd1:    word = 128'h6bc1bee22e409f96e93d7e117393172a;
      5'd2:    word = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      5'd3:    word = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      5'd4:    word = 128'h603deb1015ca71be2b73aef0857d7781;
      5'd5:    word = 128'h1f352c073b6108d72d9810a30914dff4;
      5'd6:    word = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
      5'd7:    word = 128'h8e73b0f7da0e6452c810f32b809079e5;
      5'd8:    word = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
      5'd9:    word = 128'hf5d3d58503b9699de785895a96fdbaaf;
      5'd10:   word = 128'h43b1cd7f598ece23881b00e3ed030688;
      5'd11:   word = 128'h7649abac8119b246cee98e9b12e9197d;
      5'd12:   word = 128'h5086cb9b507219ee95db113a917678b2;
      5'd13:   word = 128'h73bed6b8e3c1743b7116e69e22229516;
      5'd14:   word = 128'h3ff1caa1681fac09120eca307586e1a7;
      5'd15:   word = 128'h000102030405060708090a0b0c0d0e0f;
      5'd16:   word = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
      5'd17:   word = 128'h874d6191b620e3261bef6864990db6ce;
      5'd18:   word = 128'h9806f66b7970fdff8617187bb9fffdff;
      5'd19:   word = 128'h5ae4df3edbd5d35e5b4f09020db03eab;
      5'd20:   word = 128'h1e031dda2fbe03d1792170a0f3009cee;
      5'd21:   word = 128'h601ec313775789a5b7a7f504bbf3d228;
      5'd22:   word = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
      5'd23:   word = 128'h2b0930daa23de94ce87017ba2d84988d;
      5'd24:   word = 128'hdfc9c58db67aada613c2dd08457941a6;
      5'd25:   word = 128'hbd334f1d6e45f25ff712a214571fa5cc;
      5'd26:   word = 128'h974104846d0ad3ad7734ecb3ecee4eef;
      5'd27:   word = 128'hef7afd2270e2e60adce0ba2face6444e;
      5'd28:   word = 128'h9a4b41ba738d6c72fb16691603c18e0e;
      5'd29:   word = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
      5'd30:   word = 128'h7b0c785e27e8ad3f8223207104725dd4;
      5'd31:   word = 128'h6bc1bee22e409f96e93d7e117393172a;
      default: word = '0;
    endcase
    return word;
  endfunction

  always_ff @(posedge clk) begin
    if (en) begin
      dout <= rom_word(addr);
    end else begin
      dout <= '0;
    end
  end

endmodule

// File: rtl/key_fetch.sv
// Walks a run of consecutive key indices through a 1-cycle-latency ROM and
// presents each key on a valid/ready stream, one key per three cycles.
module key_fetch #(
  parameter int unsigned addr_bits  = key_pkg::addr_bits,
  parameter int unsigned data_width = key_pkg::data_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [addr_bits-1:0]  req_addr,
  input  logic [addr_bits-1:0]  req_count,
  input  logic                  flush,
  output logic                  rom_en,
  output logic [addr_bits-1:0]  rom_addr,
  input  logic [data_width-1:0] rom_dout,
  output logic                  key_valid,
  input  logic                  key_ready,
  output logic [data_width-1:0] key_data,
  output logic                  key_last
);
  import key_pkg::*;

  key_state_e            state_q, state_d;
  logic [addr_bits-1:0]  cur_addr_q, cur_addr_d;
  logic [addr_bits-1:0]  remaining_q, remaining_d;
  logic [data_width-1:0] key_data_q, key_data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      key_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      key_data_q  <= key_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    key_data_d  = key_data_q;

    // Flush overrides everything, including a request offered in the same cycle.
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            cur_addr_d  = req_addr;
            remaining_d = req_count;
            state_d     = StIssue;
          end
        end
        StIssue: state_d = StWait;
        StWait: begin
          key_data_d = rom_dout;
          state_d    = StOut;
        end
        StOut: begin
          if (key_ready) begin
            if (remaining_q == '0) begin
              state_d = StIdle;
            end else begin
              cur_addr_d  = cur_addr_q + addr_bits'(1);
              remaining_d = remaining_q - addr_bits'(1);
              state_d     = StIssue;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle) && !flush;
  assign rom_en    = (state_q == StIssue);
  assign rom_addr  = cur_addr_q;
  assign key_valid = (state_q == StOut);
  assign key_data  = key_data_q;
  assign key_last  = key_valid && (remaining_q == '0);

endmodule

// File: tb/tb_key_fetch.sv
// Scoreboard bench for key_fetch with the key ROM instantiated alongside it.
module tb_key_fetch;

  localparam int unsigned AW = key_pkg::addr_bits;
  localparam int unsigned DW = key_pkg::data_width;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_count;
  logic          flush;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;
  logic          key_valid;
  logic          key_ready;
  logic [DW-1:0] key_data;
  logic          key_last;

  key_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_count (req_count),
    .flush     (flush),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_data  (key_data),
    .key_last  (key_last)
  );

  ROM_key rom (
    .clk  (clk),
    .en   (rom_en),
    .addr (rom_addr),
    .dout (rom_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            rise;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] rom_tab [32];
  int            nchecks = 0;
  int            nerrors = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    nchecks++;
    if (got !== want) begin
      nerrors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic flag(input string name);
    nchecks++;
    nerrors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request; acc is the cycle index of the accepting edge.
  task automatic request(input logic [AW-1:0] addr, input logic [AW-1:0] count,
                         input int stall, input bit push, output int acc);
    int            n;
    exp_t          e;
    logic [AW-1:0] a;
    n = 0;
    while (!req_ready && n < 50) begin
      tick(1);
      n++;
    end
    if (!req_ready) flag("req_ready_timeout");
    req_addr  = addr;
    req_count = count;
    req_valid = 1'b1;
    tick(1);
    acc       = cyc;
    req_valid = 1'b0;
    if (push) begin
      for (int i = 0; i <= int'(count); i++) begin
        a      = addr + AW'(i);
        e.data = rom_tab[a];
        e.last = (i == int'(count));
        e.rise = acc + 2 + 3 * i + ((i >= 1) ? stall : 0);
        exp_q.push_back(e);
        addr_q.push_back(a);
      end
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0 || key_valid) && n < limit) begin
      tick(1);
      n++;
    end
    if (n >= limit) begin
      flag("drain_timeout");
      exp_q.delete();
      addr_q.delete();
    end
    tick(2);
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues a ROM read or presents a key.
  initial begin
    exp_t          cur;
    logic [AW-1:0] exp_a;
    bit            have_cur;
    bit            prev_valid;
    bit            prev_hs;
    have_cur   = 1'b0;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_cur   = 1'b0;
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        if (rom_en) begin
          if (addr_q.size() == 0) begin
            flag("unexpected_rom_en");
          end else begin
            exp_a = addr_q.pop_front();
            chk("rom_addr", DW'(rom_addr), DW'(exp_a));
          end
        end
        if (prev_hs) chk("valid_drop_after_handshake", DW'(key_valid), DW'(0));
        if (key_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            flag("unexpected_key_valid");
            have_cur = 1'b0;
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            chk("key_valid_rise_cycle", DW'(cyc), DW'(cur.rise));
          end
        end
        if (key_valid && have_cur) begin
          chk("key_data", key_data, cur.data);
          chk("key_last", DW'(key_last), DW'(cur.last));
        end
        prev_hs    = key_valid && key_ready;
        prev_valid = key_valid;
      end
    end
  end

  initial begin
    int   acc;
    exp_t e;
    rom_tab = '{
      128'hf69f2445df4f9b17ad2b417be66c3710, 128'h6bc1bee22e409f96e93d7e117393172a,
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
      128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4,
      128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'h8e73b0f7da0e6452c810f32b809079e5,
      128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
      128'h43b1cd7f598ece23881b00e3ed030688, 128'h7649abac8119b246cee98e9b12e9197d,
      128'h5086cb9b507219ee95db113a917678b2, 128'h73bed6b8e3c1743b7116e69e22229516,
      128'h3ff1caa1681fac09120eca307586e1a7, 128'h000102030405060708090a0b0c0d0e0f,
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 128'h874d6191b620e3261bef6864990db6ce,
      128'h9806f66b7970fdff8617187bb9fffdff, 128'h5ae4df3edbd5d35e5b4f09020db03eab,
      128'h1e031dda2fbe03d1792170a0f3009cee, 128'h601ec313775789a5b7a7f504bbf3d228,
      128'hf443e3ca4d62b59aca84e990cacaf5c5, 128'h2b0930daa23de94ce87017ba2d84988d,
      128'hdfc9c58db67aada613c2dd08457941a6, 128'hbd334f1d6e45f25ff712a214571fa5cc,
      128'h974104846d0ad3ad7734ecb3ecee4eef, 128'hef7afd2270e2e60adce0ba2face6444e,
      128'h9a4b41ba738d6c72fb16691603c18e0e, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8,
      128'h7b0c785e27e8ad3f8223207104725dd4, 128'h6bc1bee22e409f96e93d7e117393172a
    };
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_count = '0;
    flush     = 1'b0;
    key_ready = 1'b1;

    tick(2);
    chk("reset_key_valid", DW'(key_valid), DW'(0));
    chk("reset_key_last", DW'(key_last), DW'(0));
    chk("reset_key_data", key_data, DW'(0));
    chk("reset_rom_en", DW'(rom_en), DW'(0));
    chk("reset_rom_addr", DW'(rom_addr), DW'(0));
    rst = 1'b0;
    #1;
    chk("req_ready_after_reset", DW'(req_ready), DW'(1));
    tick(1);

    // Single fetch of index 2.
    request(5'd2, 5'd0, 0, 1'b1, acc);
    drain(30);

    // Burst that wraps 30, 31, 0, 1.
    request(5'd30, 5'd3, 0, 1'b1, acc);
    drain(40);

    // Backpressure: first key of the burst at index 4 held for 5 cycles.
    key_ready = 1'b0;
    request(5'd4, 5'd2, 5, 1'b1, acc);
    tick(7);
    key_ready = 1'b1;
    drain(40);

    // Flush in WAIT: only the first ROM read happens, no key is presented.
    request(5'd0, 5'd5, 0, 1'b0, acc);
    addr_q.push_back(5'd0);
    tick(1);
    flush = 1'b1;
    #1;
    chk("req_ready_during_flush", DW'(req_ready), DW'(0));
    tick(1);
    flush = 1'b0;
    #1;
    chk("req_ready_after_flush", DW'(req_ready), DW'(1));
    chk("key_valid_after_flush", DW'(key_valid), DW'(0));
    chk("key_data_kept_by_flush", key_data, rom_tab[6]);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 5'd9;
    req_count = 5'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("req_ready_flush_beats_req", DW'(req_ready), DW'(0));
      tick(1);
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    tick(10);
    chk("flush_queues_empty", DW'(exp_q.size() + addr_q.size()), DW'(0));

    // Reset while a key is held in OUT.
    key_ready = 1'b0;
    request(5'd8, 5'd3, 0, 1'b0, acc);
    addr_q.push_back(5'd8);
    e.data = rom_tab[8];
    e.last = 1'b0;
    e.rise = acc + 2;
    exp_q.push_back(e);
    tick(3);
    rst = 1'b1;
    #1;
    chk("midburst_rst_key_valid", DW'(key_valid), DW'(0));
    chk("midburst_rst_key_data", key_data, DW'(0));
    chk("midburst_rst_rom_en", DW'(rom_en), DW'(0));
    chk("midburst_rst_key_last", DW'(key_last), DW'(0));
    tick(1);
    rst       = 1'b0;
    key_ready = 1'b1;
    tick(20);
    chk("reset_queues_empty", DW'(exp_q.size() + addr_q.size()), DW'(0));

    // Full sweep of all 32 indices.
    request(5'd0, 5'd31, 0, 1'b1, acc);
    drain(200);
    chk("final_queues_empty", DW'(exp_q.size() + addr_q.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
